// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - shared state encoding and constants for the state supervisor
package state_pkg;

  typedef enum logic [1:0] {
    A0    = 2'b00,
    A1    = 2'b01,
    A2    = 2'b10,
    CHILD = 2'b11
  } state_e;

  localparam int PATTERN_LEN = 3;
  localparam logic [PATTERN_LEN-1:0] PATTERN = 3'b101;

  // Select line level that holds the sub-FSM in reset.
  localparam logic SEL_IDLE = 1'b1;

endpackage

// File: rtl/state_supervisor_if.sv
// rtl/state_supervisor_if.sv - bit stream, sub-FSM handshake and status signals of the supervisor
interface state_supervisor_if #(
  parameter int CNT_W = 4
);

  logic             in;
  logic             child_done;
  logic             child_out;
  logic             child_sel;
  logic             out1;
  logic             out2;
  logic [CNT_W-1:0] pass_cnt;
  logic             busy;
  logic             timeout;

  modport master (
    output in, child_done, child_out,
    input  child_sel, out1, out2, pass_cnt, busy, timeout
  );

  modport slave (
    input  in, child_done, child_out,
    output child_sel, out1, out2, pass_cnt, busy, timeout
  );

endinterface

// File: rtl/state_tmo.sv
// rtl/state_tmo.sv - watchdog counter bounding how long the sub-FSM may hold the stream
module state_tmo #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Expiry is judged on the count held before this edge's increment.
  assign expire = en && (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/state_supervisor.sv
// rtl/state_supervisor.sv - 1-0-1 detector that hands the stream to a sub-FSM; watchdog under STATE_SUPERVISOR_TIMEOUT_EN
module state_supervisor
  import state_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  state_supervisor_if.slave    bus
);

  state_e           state_q;
  state_e           state_d;
  logic             child_sel_q;
  logic             child_sel_d;
  logic             out1_q;
  logic             out1_d;
  logic             out2_q;
  logic             out2_d;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] pass_cnt_d;
  logic             busy_q;
  logic             busy_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             tmo_expire;

`ifdef STATE_SUPERVISOR_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  // Ternary keeps an undriven child_done out of the counter while idle.
  assign tmo_clr = (state_q != CHILD);
  assign tmo_en  = (state_q == CHILD) ? ~bus.child_done : 1'b0;

  state_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT < 1);
  assign tmo_expire     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    out1_d     = 1'b0;
    out2_d     = 1'b0;
    timeout_d  = 1'b0;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      A0: begin
        if (bus.in == PATTERN[PATTERN_LEN-1]) state_d = A1;
      end
      A1: begin
        if (bus.in == PATTERN[PATTERN_LEN-2]) state_d = A2;
      end
      A2: begin
        if (bus.in == PATTERN[0]) begin
          state_d = CHILD;
          out1_d  = 1'b1;
        end else begin
          state_d = A0;
        end
      end
      CHILD: begin
        // Sub-FSM inputs are only looked at here; outside CHILD they may be X.
        out2_d = bus.child_out;
        if (bus.child_done) begin
          state_d = A0;
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else if (tmo_expire) begin
          state_d   = A0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = A0;
    endcase
    child_sel_d = (state_d == CHILD) ? ~SEL_IDLE : SEL_IDLE;
    busy_d      = (state_d == CHILD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= A0;
      child_sel_q <= SEL_IDLE;
      out1_q      <= 1'b0;
      out2_q      <= 1'b0;
      pass_cnt_q  <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      child_sel_q <= child_sel_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      pass_cnt_q  <= pass_cnt_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.child_sel = child_sel_q;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_state_supervisor.sv
// tb/tb_state_supervisor.sv - directed self-checking bench for state_supervisor
module tb_state_supervisor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   wd_cnt;

  state_supervisor_if #(.CNT_W(2)) bus ();

  state_supervisor #(
    .CNT_W   (2),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic sel, input logic o1, input logic o2,
                            input logic [7:0] cnt, input logic bsy, input logic tmo);
    chk({tag, "/child_sel"}, {7'b0, bus.child_sel}, {7'b0, sel});
    chk({tag, "/out1"},      {7'b0, bus.out1},      {7'b0, o1});
    chk({tag, "/out2"},      {7'b0, bus.out2},      {7'b0, o2});
    chk({tag, "/pass_cnt"},  {6'b0, bus.pass_cnt},  cnt);
    chk({tag, "/busy"},      {7'b0, bus.busy},      {7'b0, bsy});
    chk({tag, "/timeout"},   {7'b0, bus.timeout},   {7'b0, tmo});
  endtask

  task automatic drive(input logic i, input logic d, input logic o);
    bus.in         = i;
    bus.child_done = d;
    bus.child_out  = o;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input string tag, input logic [7:0] cnt);
    drive(1'b1, 1'bx, 1'bx);
    expect_out({tag, "_1"}, 1'b1, 1'b0, 1'b0, cnt, 1'b0, 1'b0);
    drive(1'b0, 1'bx, 1'bx);
    expect_out({tag, "_10"}, 1'b1, 1'b0, 1'b0, cnt, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out({tag, "_101"}, 1'b0, 1'b1, 1'b0, cnt, 1'b1, 1'b0);
  endtask

  initial begin
`ifdef STATE_SUPERVISOR_TIMEOUT_EN
    wd_cnt = 2;
`else
    wd_cnt = 3;
`endif
    bus.in         = 1'b0;
    bus.child_done = 1'bx;
    bus.child_out  = 1'bx;

    for (int k = 0; k < 4; k++) begin
      bus.in = k[0];
      @(posedge clk);
      #1;
      expect_out("reset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    end
    rst = 1'b0;

    enter("basic", 8'd0);
    drive(1'b1, 1'b0, 1'b1);
    expect_out("basic_c1", 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    expect_out("basic_c2", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_out("basic_done", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);

    drive(1'b1, 1'bx, 1'bx);
    expect_out("ovl_1", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out("ovl_11", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    drive(1'b0, 1'bx, 1'bx);
    expect_out("ovl_110", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out("ovl_1101", 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_out("ovl_done", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);

    enter("wd", 8'd2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      expect_out("wd_run", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
`ifdef STATE_SUPERVISOR_TIMEOUT_EN
    expect_out("wd_expire", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
    drive(1'b0, 1'bx, 1'bx);
    expect_out("wd_after", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
`else
    expect_out("wd_none", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_out("wd_done", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
`endif

    enter("tie", 8'(wd_cnt));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      expect_out("tie_run", 1'b0, 1'b0, 1'b0, 8'(wd_cnt), 1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0);
    expect_out("tie_done", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);

    enter("hist", 8'd3);
    drive(1'b1, 1'b1, 1'b0);
    expect_out("hist_done", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    drive(1'b0, 1'bx, 1'bx);
    expect_out("hist_0", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out("hist_01", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    drive(1'b0, 1'bx, 1'bx);
    expect_out("hist_010", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out("hist_0101", 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    expect_out("hist_ret", 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);

    enter("sat", 8'd3);
    drive(1'b0, 1'b1, 1'b0);
    expect_out("sat_done", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);

    enter("arst", 8'd3);
    #3;
    rst = 1'b1;
    #1;
    expect_out("arst_async", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    expect_out("arst_1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 1'bx, 1'bx);
    expect_out("arst_10", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'bx, 1'bx);
    expect_out("arst_101", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_out("arst_done", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/state_supervisor.md
# state_supervisor

Parent-level FSM for the state-within-state chain; sits directly upstream of the sequence sub-FSM. It scans serial `in` for the pattern 1-0-1 and, on a match, hands control of the bit stream to the sub-FSM by releasing its select/reset line. When the sub-FSM reports completion, it takes control back, re-arms its own detector and counts the completed handoff. An optional watchdog reclaims control from a stuck sub-FSM.

## Interface
- `CNT_W`, default 4: width of the handoff counter `pass_cnt`.
- `TIMEOUT`, default 15: maximum number of sampling edges the sub-FSM may run before abort. Must be ≥1. Used only with the watchdog macro.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in` input 1: serial data bit; the same net is also routed to the sub-FSM.
- `child_done` input 1: sub-FSM completion (its `state_out`). May be X while `child_sel`=1.
- `child_out` input 1: sub-FSM detect output (its `out2`). May be X while `child_sel`=1.
- `child_sel` output 1: drives the sub-FSM `state_select_in`. 1 = sub-FSM held in reset. 0 = sub-FSM active.
- `out1` output 1: one-cycle pulse on a 1-0-1 match.
- `out2` output 1: registered, gated copy of `child_out`.
- `pass_cnt` output CNT_W: count of completed handoffs, saturating.
- `busy` output 1: 1 while in state CHILD.
- `timeout` output 1: one-cycle abort pulse. Tied 0 without the macro.

## Operation
- States: A0 (no match), A1 (seen 1), A2 (seen 10), CHILD.
- A0: `in`=1 → A1; otherwise stay in A0.
- A1: `in`=0 → A2; `in`=1 → stay in A1 (overlap kept).
- A2: `in`=1 → CHILD and pulse `out1`; `in`=0 → A0.
- CHILD: `child_done`=1 → A0 and `pass_cnt` increments. Otherwise stay in CHILD, subject to the watchdog.
- `child_sel` is 0 exactly while in CHILD and 1 in every other state.
- `out2 <= (state==CHILD) & child_out`.
- `child_done` and `child_out` are sampled only in CHILD. X on these inputs must never reach any register outside CHILD.
- On leaving CHILD the detector restarts at A0 with no history.
- `pass_cnt` saturates at 2^CNT_W−1 and never wraps.
- `busy` is 1 exactly while in CHILD.

## Timing
- Reset values: state A0, `child_sel`=1, `out1`=0, `out2`=0, `pass_cnt`=0, `busy`=0, `timeout`=0, watchdog count 0.
- All outputs are registered.
- Match latency: the edge that samples the final 1 of 1-0-1 sets `out1`=1, `child_sel`=0 and `busy`=1 together. `out1` clears at the next edge.
- Bit ownership: the bit sampled at the match edge belongs to the supervisor. The sub-FSM's first bit is the one sampled at the next edge. No bit is shared.
- Return: `child_done` is sampled at edge k. At edge k, `child_sel` goes to 1 and `pass_cnt` increments. The bit at edge k is the sub-FSM's last bit.
- Reset mid-CHILD: `child_sel` goes to 1 asynchronously, which also resets the sub-FSM. No `pass_cnt` update occurs.
- `child_done`=1 and watchdog expiry at the same edge: done wins. The handoff counts as a pass and `timeout` stays 0.

## Configuration
- Macro: `STATE_SUPERVISOR_TIMEOUT_EN`.
- Defined:
  - Watchdog counter of width $clog2(TIMEOUT+1).
  - The counter clears on entry to CHILD and increments on each CHILD edge without `child_done`.
  - If it already holds TIMEOUT−1 at an edge with no done, the supervisor goes to A0, sets `child_sel`=1, pulses `timeout` for one cycle and leaves `pass_cnt` unchanged.
- Undefined:
  - No counter is built.
  - CHILD exits only on `child_done` or `rst`.
  - `timeout` is constant 0.

## Structure
- Shared package `state_pkg` holds:
  - the state encoding: A0=2'b00, A1=2'b01, A2=2'b10, CHILD=2'b11;
  - the pattern-length localparam;
  - the select-line polarity constant SEL_IDLE=1'b1.
- Sub-module: `state_tmo`, the watchdog counter with clear/enable/expire. It is instantiated only under the macro.
- The sub-FSM is not instantiated inside this block; it is wired alongside it at the next level up.

## Test plan
- Reset: hold `rst`=1 with `in` toggling → `child_sel`=1, `out1`=0, `pass_cnt`=0, `busy`=0 throughout.
- Basic handoff, with the sub-FSM model connected: `in`=1,0,1 → `out1`=1 for one cycle and `child_sel`=0. Then `in`=1,1,0 → `child_done` at the third edge, `child_sel`=1, `pass_cnt`=1.
- Overlap: `in`=1,1,0,1 → `out1` pulses after the 4th edge and not before.
- Watchdog, with TIMEOUT=4 and the macro defined: after a handoff, `in`=0 for 4 edges → `timeout` pulses on the 4th edge, `child_sel`=1, `pass_cnt` unchanged, state A0.
- Saturation, with CNT_W=2: five complete handoffs → `pass_cnt` reads 1,2,3,3,3.
- Asynchronous reset mid-CHILD: assert `rst` between edges → `child_sel`=1 and `busy`=0 immediately, with no clock edge. After release, 1-0-1 is required again before the next handoff.
